// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a registered shifter with a one-entry valid/ready output.
// Define SHIFT_ARBITER_ROTATE_EN to make op 11 rotate right by amt instead of passing the value through.
module shift_arbiter #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid_0,
  output logic                 req_ready_0,
  input  logic [WIDTH-1:0]     req_value_0,
  input  logic [1:0]           req_op_0,
  input  logic [AMT_WIDTH-1:0] req_amt_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_1,
  input  logic [WIDTH-1:0]     req_value_1,
  input  logic [1:0]           req_op_1,
  input  logic [AMT_WIDTH-1:0] req_amt_1,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_result,
  output logic                 resp_id
);

  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_id_q, resp_id_d;
  logic             last_grant_q, last_grant_d;

  logic                 slot_free;
  logic                 grant_0, grant_1;
  logic [WIDTH-1:0]     sel_value;
  logic [1:0]           sel_op;
  logic [AMT_WIDTH-1:0] sel_amt;
  logic [WIDTH-1:0]     shifted;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    slot_free = !resp_valid_q | resp_ready;
    grant_0   = slot_free & req_valid_0 & (!req_valid_1 | last_grant_q);
    grant_1   = slot_free & req_valid_1 & (!req_valid_0 | !last_grant_q);
  end

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  always_comb begin
    sel_value = grant_1 ? req_value_1 : req_value_0;
    sel_op    = grant_1 ? req_op_1    : req_op_0;
    sel_amt   = grant_1 ? req_amt_1   : req_amt_0;
  end

  always_comb begin
    shifted = sel_value;
    case (sel_op)
      2'b00:   shifted = sel_value >> sel_amt;
      2'b01:   shifted = $signed(sel_value) >>> sel_amt;
      2'b10:   shifted = sel_value << sel_amt;
      default: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        // A left shift by WIDTH yields zero, so amt=0 degenerates cleanly to pass-through.
        shifted = (sel_value >> sel_amt) | (sel_value << (WIDTH - int'(sel_amt)));
`else
        shifted = sel_value;
`endif
      end
    endcase
  end

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_id_d     = resp_id_q;
    last_grant_d  = last_grant_q;
    if (grant_0 | grant_1) begin
      resp_valid_d  = 1'b1;
      resp_result_d = shifted;
      resp_id_d     = grant_1;
      last_grant_d  = grant_1;
    end else if (resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_id_q     <= resp_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_id     = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed plus randomized bench for shift_arbiter against a bit-level behavioural model.
module tb_shift_arbiter;
  localparam int W = 32;
  localparam int A = 5;

  logic clock = 1'b0;
  logic reset;
  logic req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [W-1:0] req_value_0, req_value_1;
  logic [1:0] req_op_0, req_op_1;
  logic [A-1:0] req_amt_0, req_amt_1;
  logic resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_result;

  shift_arbiter #(.WIDTH(W), .AMT_WIDTH(A)) dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_value_0(req_value_0),
    .req_op_0(req_op_0), .req_amt_0(req_amt_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_value_1(req_value_1),
    .req_op_1(req_op_1), .req_amt_1(req_amt_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_id(resp_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit         m_valid = 0;
  bit [W-1:0] m_result = '0;
  bit         m_id = 0;
  bit         m_last = 1;
  logic       obs_r0, obs_r1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit evaluation of the shift rules.
  function automatic bit [W-1:0] ref_shift(input bit [W-1:0] v, input bit [1:0] op, input int amt);
    bit [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (op)
        2'd0: r[i] = (i + amt < W) ? v[i + amt] : 1'b0;
        2'd1: r[i] = (i + amt < W) ? v[i + amt] : v[W-1];
        2'd2: r[i] = (i >= amt) ? v[i - amt] : 1'b0;
        default: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
          r[i] = v[(i + amt) % W];
`else
          r[i] = v[i];
`endif
        end
      endcase
    end
    return r;
  endfunction

  // One clock: check combinational readys, advance the model on the edge, check registered outputs.
  task automatic step();
    int g;
    bit free;
    #1;
    free = !m_valid || resp_ready;
    g = -1;
    if (free) begin
      if (req_valid_0 && req_valid_1) g = m_last ? 0 : 1;
      else if (req_valid_0) g = 0;
      else if (req_valid_1) g = 1;
    end
    obs_r0 = req_ready_0;
    obs_r1 = req_ready_1;
    chk("req_ready_0", 32'(req_ready_0), 32'(g == 0));
    chk("req_ready_1", 32'(req_ready_1), 32'(g == 1));
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_result = '0; m_id = 0; m_last = 1;
    end else if (g == 0) begin
      m_valid = 1; m_result = ref_shift(req_value_0, req_op_0, int'(req_amt_0)); m_id = 0; m_last = 0;
    end else if (g == 1) begin
      m_valid = 1; m_result = ref_shift(req_value_1, req_op_1, int'(req_amt_1)); m_id = 1; m_last = 1;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_result", resp_result, m_result);
    chk("resp_id", 32'(resp_id), 32'(m_id));
  endtask

  initial begin
    reset = 1; resp_ready = 0;
    req_valid_0 = 0; req_value_0 = '0; req_op_0 = 0; req_amt_0 = 0;
    req_valid_1 = 0; req_value_1 = '0; req_op_1 = 0; req_amt_1 = 0;
    step(); step();
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_result", resp_result, 32'd0);
    reset = 0;

    // Arithmetic right of the sign bit fills the word.
    resp_ready = 1;
    req_valid_0 = 1; req_value_0 = 32'h8000_0000; req_op_0 = 2'b01; req_amt_0 = 5'd31;
    step();
    chk("asr_ready0", 32'(obs_r0), 32'd1);
    chk("asr_result", resp_result, 32'hFFFF_FFFF);
    chk("asr_id", 32'(resp_id), 32'd0);
    req_valid_0 = 0;

    // Fresh reset so the first tie goes to port 0.
    reset = 1; step(); reset = 0;
    req_valid_0 = 1; req_value_0 = 32'h0000_000F; req_op_0 = 2'b10; req_amt_0 = 5'd4;
    req_valid_1 = 1; req_value_1 = 32'h0000_000F; req_op_1 = 2'b10; req_amt_1 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_grant1", 32'(obs_r1), 32'(i % 2));
      chk("alt_result", resp_result, 32'h0000_00F0);
      chk("alt_id", 32'(resp_id), 32'(i % 2));
    end

    // Stall with the slot full.
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 32'({obs_r1, obs_r0}), 32'd0);
      chk("stall_result", resp_result, 32'h0000_00F0);
      chk("stall_id", 32'(resp_id), 32'd1);
    end
    resp_ready = 1;
    step();
    chk("unstall_grant0", 32'(obs_r0), 32'd1);
    chk("unstall_id", 32'(resp_id), 32'd0);

    // Port 1 alone.
    req_valid_0 = 0;
    req_value_1 = 32'hF000_0000; req_op_1 = 2'b00; req_amt_1 = 5'd28;
    step();
    chk("lsr_result", resp_result, 32'h0000_000F);
    chk("lsr_id", 32'(resp_id), 32'd1);
    req_op_1 = 2'b11; req_amt_1 = 5'd4;
    step();
`ifdef SHIFT_ARBITER_ROTATE_EN
    chk("op11_result", resp_result, 32'h0F00_0000);
`else
    chk("op11_result", resp_result, 32'hF000_0000);
`endif

    // Reset while a result is held drops it and re-arms the pointer.
    req_valid_1 = 0; resp_ready = 0;
    reset = 1; step(); reset = 0;
    chk("midreset_valid", 32'(resp_valid), 32'd0);
    chk("midreset_result", resp_result, 32'd0);
    req_valid_0 = 1; req_valid_1 = 1; resp_ready = 1;
    step();
    chk("midreset_tie", 32'(obs_r0), 32'd1);
    req_valid_1 = 0;

    // Zero amount is identity for every op.
    for (int op = 0; op < 4; op++) begin
      req_value_0 = 32'h1234_5678; req_op_0 = 2'(op); req_amt_0 = 5'd0;
      step();
      chk("amt0_result", resp_result, 32'h1234_5678);
    end
    req_valid_0 = 0;

    // Random traffic; requesters hold their operation until accepted.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid_0 || obs_r0) begin
        req_valid_0 = $urandom_range(0, 2) != 0;
        req_value_0 = $urandom; req_op_0 = 2'($urandom); req_amt_0 = 5'($urandom);
      end
      if (!req_valid_1 || obs_r1) begin
        req_valid_1 = $urandom_range(0, 2) != 0;
        req_value_1 = $urandom; req_op_1 = 2'($urandom); req_amt_1 = 5'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
